// File: rtl/cnna_mul_arb.sv
// Round-robin scheduler sharing one external 15u x 26s -> 32 multiplier among NUM_REQ requesters.
// Define CNNA_MUL_ARB_FIXPRI_EN for fixed lowest-index-wins priority instead of round-robin.
module cnna_mul_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_vld,
    output logic [NUM_REQ-1:0]     req_rdy,
    input  logic [NUM_REQ*15-1:0]  req_din0,
    input  logic [NUM_REQ*26-1:0]  req_din1,
    output logic [14:0]            mul_din0,
    output logic [25:0]            mul_din1,
    input  logic [31:0]            mul_dout,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_dout
);
    localparam int A_W = 15;
    localparam int B_W = 26;
    localparam int P_W = 32;

    logic                  r_s1_vld;
    logic [ID_W-1:0]       r_s1_id;
    logic [A_W-1:0]        r_s1_a;
    logic signed [B_W-1:0] r_s1_b;

    logic                  r_rsp_vld;
    logic [ID_W-1:0]       r_rsp_id;
    logic [P_W-1:0]        r_rsp_dout;

    logic                  w_adv1;
    logic                  w_adv2;
    logic                  w_xfer;
    logic                  w_gnt_any;
    logic [ID_W-1:0]       w_gnt_id;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_lo_any;
    logic [ID_W-1:0]       w_lo_id;
    logic [A_W-1:0]        w_sel_a;
    logic [B_W-1:0]        w_sel_b;

`ifndef CNNA_MUL_ARB_FIXPRI_EN
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       w_ptr_nxt;
    logic                  w_hi_any;
    logic [ID_W-1:0]       w_hi_id;
`endif

    assign w_adv2 = !r_rsp_vld || rsp_rdy;
    assign w_adv1 = !r_s1_vld || w_adv2;

    // Lowest valid index overall; in round-robin mode it is the wrap-around fallback.
    always_comb begin
        w_lo_any = 1'b0;
        w_lo_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_lo_any && req_vld[i]) begin
                w_lo_any = 1'b1;
                w_lo_id  = ID_W'(i);
            end
        end
    end

`ifndef CNNA_MUL_ARB_FIXPRI_EN
    // First valid index at or above ptr; wraps to w_lo_id when none exists.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_hi_any && req_vld[i] && (i >= int'(r_ptr))) begin
                w_hi_any = 1'b1;
                w_hi_id  = ID_W'(i);
            end
        end
    end

    assign w_gnt_id  = w_hi_any ? w_hi_id : w_lo_id;
    assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
`else
    assign w_gnt_id  = w_lo_id;
`endif

    assign w_gnt_any = w_lo_any;

    always_comb begin
        w_grant = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant[i] = w_gnt_any && (w_gnt_id == ID_W'(i));
            if (w_grant[i]) begin
                w_sel_a = req_din0[i*A_W +: A_W];
                w_sel_b = req_din1[i*B_W +: B_W];
            end
        end
    end

    // Nobody is accepted while reset is held, even though the pipeline looks empty.
    assign req_rdy = (w_adv1 && !ap_rst) ? w_grant : '0;
    assign w_xfer  = w_adv1 && !ap_rst && w_gnt_any;

`ifndef CNNA_MUL_ARB_FIXPRI_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    // S1: issue register, drives the shared multiplier directly.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_s1_vld <= 1'b0;
            r_s1_id  <= '0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
        end else if (w_adv1) begin
            r_s1_vld <= w_xfer;
            if (w_xfer) begin
                r_s1_id <= w_gnt_id;
                r_s1_a  <= w_sel_a;
                r_s1_b  <= w_sel_b;
            end
        end
    end

    assign mul_din0 = r_s1_a;
    assign mul_din1 = r_s1_b;

    // S2: response register, captures the multiplier result unmodified.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_dout <= '0;
        end else if (w_adv2) begin
            r_rsp_vld  <= r_s1_vld;
            r_rsp_id   <= r_s1_id;
            r_rsp_dout <= mul_dout;
        end
    end

    assign rsp_vld  = r_rsp_vld;
    assign rsp_id   = r_rsp_id;
    assign rsp_dout = r_rsp_dout;

endmodule
